// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: valid/ready input from fetch, one output register
// toward execute, load-use bubble insertion, flush, and saturating stall/illegal counters.
module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [31:0]           i_inst,
  input  logic                  i_flush,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [4:0]            o_rs,
  output logic [4:0]            o_rt,
  output logic [4:0]            o_wr_reg,
  output logic [DATA_WIDTH-1:0] o_imm_ext,
  output logic [25:0]           o_target,
  output logic                  o_regWr,
  output logic                  o_memWr,
  output logic                  o_memToReg,
  output logic                  o_ALUsrc,
  output logic                  o_jump,
  output logic                  o_branch,
  output logic [1:0]            o_ALUcntrl,
  output logic                  o_illegal,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_illegal_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [5:0]            w_op, w_funct;
  logic [4:0]            w_rs, w_rt, w_rd, w_wr_reg;
  logic                  w_regWr, w_memWr, w_memToReg, w_ALUsrc, w_jump, w_branch;
  logic                  w_regDst, w_jal, w_zext, w_illegal, w_reads_rs, w_reads_rt;
  logic [1:0]            w_alu;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_hazard, w_accept;

  logic                  r_valid;
  logic [4:0]            r_rs, r_rt, r_wr_reg;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [25:0]           r_target;
  logic                  r_regWr, r_memWr, r_memToReg, r_ALUsrc, r_jump, r_branch, r_illegal;
  logic [1:0]            r_alu;
  logic [CNT_WIDTH-1:0]  r_stall_cnt, r_illegal_cnt;

  assign w_op    = i_inst[31:26];
  assign w_funct = i_inst[5:0];
  assign w_rs    = i_inst[25:21];
  assign w_rt    = i_inst[20:16];
  assign w_rd    = i_inst[15:11];

  always_comb begin
    w_regWr    = 1'b0;
    w_memWr    = 1'b0;
    w_memToReg = 1'b0;
    w_ALUsrc   = 1'b0;
    w_jump     = 1'b0;
    w_branch   = 1'b0;
    w_regDst   = 1'b0;
    w_jal      = 1'b0;
    w_zext     = 1'b0;
    w_illegal  = 1'b0;
    w_alu      = 2'd0;
    w_reads_rs = 1'b1;
    w_reads_rt = 1'b0;
    case (w_op)
      6'h23: begin w_regWr = 1'b1; w_memToReg = 1'b1; w_ALUsrc = 1'b1; end
      6'h2b: begin w_memWr = 1'b1; w_ALUsrc = 1'b1; w_reads_rt = 1'b1; end
      6'h08: begin w_regWr = 1'b1; w_ALUsrc = 1'b1; end
      6'h0e: begin w_regWr = 1'b1; w_ALUsrc = 1'b1; w_alu = 2'd3; w_zext = 1'b1; end
      6'h04, 6'h05: begin w_branch = 1'b1; w_alu = 2'd3; w_reads_rt = 1'b1; end
      6'h02: begin w_jump = 1'b1; w_reads_rs = 1'b0; end
      6'h03: begin w_jump = 1'b1; w_regWr = 1'b1; w_jal = 1'b1; w_reads_rs = 1'b0; end
      6'h00: begin
        case (w_funct)
          6'h20: begin w_regWr = 1'b1; w_regDst = 1'b1; w_reads_rt = 1'b1; end
          6'h22: begin w_regWr = 1'b1; w_regDst = 1'b1; w_reads_rt = 1'b1; w_alu = 2'd1; end
          6'h2a: begin w_regWr = 1'b1; w_regDst = 1'b1; w_reads_rt = 1'b1; w_alu = 2'd2; end
          6'h08: w_jump = 1'b1;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_wr_reg = w_regDst ? w_rd : (w_jal ? 5'd31 : w_rt);
  assign w_imm    = {{(DATA_WIDTH-16){i_inst[15] & ~w_zext}}, i_inst[15:0]};

  // Load in the output register whose result the incoming instruction needs right now.
  assign w_hazard = r_valid && r_memToReg && (r_wr_reg != 5'd0) && i_in_valid &&
                    ((w_reads_rs && (w_rs == r_wr_reg)) || (w_reads_rt && (w_rt == r_wr_reg)));

  assign o_in_ready = (!r_valid || i_out_ready) && !w_hazard && !i_flush;
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid       <= 1'b0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_wr_reg      <= '0;
      r_imm         <= '0;
      r_target      <= '0;
      r_regWr       <= 1'b0;
      r_memWr       <= 1'b0;
      r_memToReg    <= 1'b0;
      r_ALUsrc      <= 1'b0;
      r_jump        <= 1'b0;
      r_branch      <= 1'b0;
      r_illegal     <= 1'b0;
      r_alu         <= 2'd0;
      r_stall_cnt   <= '0;
      r_illegal_cnt <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_rs       <= w_rs;
      r_rt       <= w_rt;
      r_wr_reg   <= w_wr_reg;
      r_imm      <= w_imm;
      r_target   <= i_inst[25:0];
      r_regWr    <= w_regWr;
      r_memWr    <= w_memWr;
      r_memToReg <= w_memToReg;
      r_ALUsrc   <= w_ALUsrc;
      r_jump     <= w_jump;
      r_branch   <= w_branch;
      r_illegal  <= w_illegal;
      r_alu      <= w_alu;
      if (w_illegal && (r_illegal_cnt != CNT_MAX))
        r_illegal_cnt <= r_illegal_cnt + CNT_ONE;
    end else if (r_valid && i_out_ready) begin
      // Either a plain drain or a load-use bubble; only the latter is counted.
      r_valid <= 1'b0;
      if (w_hazard && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign o_out_valid   = r_valid;
  assign o_rs          = r_rs;
  assign o_rt          = r_rt;
  assign o_wr_reg      = r_wr_reg;
  assign o_imm_ext     = r_imm;
  assign o_target      = r_target;
  assign o_regWr       = r_regWr;
  assign o_memWr       = r_memWr;
  assign o_memToReg    = r_memToReg;
  assign o_ALUsrc      = r_ALUsrc;
  assign o_jump        = r_jump;
  assign o_branch      = r_branch;
  assign o_ALUcntrl    = r_alu;
  assign o_illegal     = r_illegal;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, load-use bubbles, backpressure,
// flush, illegal counting and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst;
  logic [4:0]  rs, rt, wr_reg;
  logic [31:0] imm_ext;
  logic [25:0] target;
  logic        regWr, memWr, memToReg, ALUsrc, jump, branch, illegal;
  logic [1:0]  ALUcntrl;
  logic [15:0] stall_cnt, illegal_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_inst(inst), .i_flush(flush), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_rs(rs), .o_rt(rt), .o_wr_reg(wr_reg), .o_imm_ext(imm_ext), .o_target(target),
    .o_regWr(regWr), .o_memWr(memWr), .o_memToReg(memToReg), .o_ALUsrc(ALUsrc),
    .o_jump(jump), .o_branch(branch), .o_ALUcntrl(ALUcntrl), .o_illegal(illegal),
    .o_stall_cnt(stall_cnt), .o_illegal_cnt(illegal_cnt)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] add_rd(input logic [4:0] rd);
    return 32'h012A0020 | (32'(rd) << 11);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; inst = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || regWr !== 1'b0 || wr_reg !== 5'd0 || imm_ext !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b regWr=%b wr_reg=%0d imm=%h required 0", out_valid, regWr, wr_reg, imm_ext);
    end
    n_checks++;
    if (stall_cnt !== 16'd0 || illegal_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: stall=%0d illegal=%0d required 0/0", stall_cnt, illegal_cnt);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; inst = 32'h012A4020; out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_in_ready[%0d]: got %b required 1", i, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || rs !== 5'd9 || rt !== 5'd10 || wr_reg !== 5'd8 ||
          regWr !== 1'b1 || ALUcntrl !== 2'd0 || memToReg !== 1'b0 || illegal !== 1'b0) begin
        n_fail++; $display("FAIL stream_add[%0d]: v=%b rs=%0d rt=%0d wr=%0d regWr=%b alu=%0d required 1/9/10/8/1/0",
                           i, out_valid, rs, rt, wr_reg, regWr, ALUcntrl);
      end
      $display("stream ADD %0d: out_valid=%b wr_reg=%0d", i, out_valid, wr_reg);
    end
    n_checks++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stream_no_bubble: stall_cnt=%0d required 0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; out_ready = 1'b1; inst = 32'h8C880004;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || memToReg !== 1'b1 || wr_reg !== 5'd8 || ALUsrc !== 1'b1) begin
      n_fail++; $display("FAIL lw_decode: v=%b memToReg=%b wr=%0d ALUsrc=%b required 1/1/8/1", out_valid, memToReg, wr_reg, ALUsrc);
    end
    inst = 32'h01095820;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL hazard_in_ready: got %b required 0", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL hazard_bubble: out_valid=%b stall=%0d required 0/1", out_valid, stall_cnt);
    end
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hazard_release: in_ready=%b required 1", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || wr_reg !== 5'd11 || rs !== 5'd8) begin
      n_fail++; $display("FAIL hazard_emerge: v=%b wr=%0d rs=%0d required 1/11/8", out_valid, wr_reg, rs);
    end
    $display("load-use: stall_cnt=%0d", stall_cnt);
    inst = 32'h8C800004;
    tick();
    inst = 32'h00095820;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL r0_no_hazard: in_ready=%b required 1", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || wr_reg !== 5'd11 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL r0_emerge: v=%b wr=%0d stall=%0d required 1/11/1", out_valid, wr_reg, stall_cnt);
    end
    $display("load to $0: no bubble, stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_extend();
    in_valid = 1'b1; out_ready = 1'b1; inst = 32'h2128FFFC;
    tick();
    n_checks++;
    if (imm_ext !== 32'hFFFFFFFC || regWr !== 1'b1 || ALUsrc !== 1'b1 || ALUcntrl !== 2'd0) begin
      n_fail++; $display("FAIL addi_sext: imm=%h regWr=%b alu=%0d required fffffffc/1/0", imm_ext, regWr, ALUcntrl);
    end
    inst = 32'h3928FFFC;
    tick();
    n_checks++;
    if (imm_ext !== 32'h0000FFFC || ALUcntrl !== 2'd3 || wr_reg !== 5'd8) begin
      n_fail++; $display("FAIL xori_zext: imm=%h alu=%0d wr=%0d required 0000fffc/3/8", imm_ext, ALUcntrl, wr_reg);
    end
    inst = 32'h0C000010;
    tick();
    n_checks++;
    if (wr_reg !== 5'd31 || jump !== 1'b1 || regWr !== 1'b1 || target !== 26'h10 || branch !== 1'b0) begin
      n_fail++; $display("FAIL jal: wr=%0d jump=%b regWr=%b target=%h required 31/1/1/10", wr_reg, jump, regWr, target);
    end
    $display("extend: addi/xori/jal decoded, last wr_reg=%0d", wr_reg);
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; out_ready = 1'b1; inst = add_rd(5'd1);
    tick();
    out_ready = 1'b0; inst = add_rd(5'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || wr_reg !== 5'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: v=%b wr=%0d required 1/1", i, out_valid, wr_reg);
      end
      $display("backpressure cycle %0d: wr_reg=%0d", i, wr_reg);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || wr_reg !== 5'd2) begin
      n_fail++; $display("FAIL bp_release: v=%b wr=%0d required 1/2", out_valid, wr_reg);
    end
    inst = add_rd(5'd3);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || wr_reg !== 5'd3) begin
      n_fail++; $display("FAIL bp_next: v=%b wr=%0d required 1/3", out_valid, wr_reg);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b1; inst = 32'h8C880004;
    tick();
    inst = 32'h01095820; flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_ready: got %b required 0", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL flush_stall: v=%b stall=%0d required 0/1", out_valid, stall_cnt);
    end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_dropped: out_valid=%b required 0", out_valid);
    end
    $display("flush during hazard: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_illegal_and_reset();
    in_valid = 1'b1; out_ready = 1'b1; inst = 32'hFC000000;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || regWr !== 1'b0 || memWr !== 1'b0 ||
        jump !== 1'b0 || ALUcntrl !== 2'd0 || illegal_cnt !== 16'd1) begin
      n_fail++; $display("FAIL illegal_first: v=%b ill=%b regWr=%b memWr=%b cnt=%0d required 1/1/0/0/1",
                         out_valid, illegal, regWr, memWr, illegal_cnt);
    end
    tick();
    n_checks++;
    if (illegal !== 1'b1 || illegal_cnt !== 16'd2) begin
      n_fail++; $display("FAIL illegal_second: ill=%b cnt=%0d required 1/2", illegal, illegal_cnt);
    end
    $display("illegal: illegal_cnt=%0d", illegal_cnt);
    inst = 32'h8C880004;
    tick();
    inst = 32'h01095820;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || regWr !== 1'b0 || memToReg !== 1'b0 || wr_reg !== 5'd0 ||
        stall_cnt !== 16'd0 || illegal_cnt !== 16'd0) begin
      n_fail++; $display("FAIL async_reset: v=%b regWr=%b wr=%0d stall=%0d ill=%0d required all 0",
                         out_valid, regWr, wr_reg, stall_cnt, illegal_cnt);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || wr_reg !== 5'd11 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL post_reset_accept: v=%b wr=%0d stall=%0d required 1/11/0", out_valid, wr_reg, stall_cnt);
    end
    $display("async reset: counters cleared, restart wr_reg=%0d", wr_reg);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_extend();
    test_backpressure();
    test_flush();
    test_illegal_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage for the single-cycle-to-pipelined CPU upgrade.
- Accepts 32-bit instructions from fetch on a valid/ready interface and presents decoded fields plus control to execute from one output register.
- Inserts a one-cycle bubble on load-use hazards and supports flush for taken branches and jumps.
- Keeps saturating stall and illegal-instruction counters for the lab performance report.

Parameters:
DATA_WIDTH, 32, width of extended immediate output (>=16)
CNT_WIDTH, 16, width of stall/illegal counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
inst  in  32  instruction word
flush  in  1  discard held and incoming instruction
out_valid  out  1  decoded output register holds valid instruction
out_ready  in  1  execute consumes output this cycle
rs, rt  out  5  source register fields
wr_reg  out  5  destination: rd if regDst, 31 if JAL, else rt
imm_ext  out  DATA_WIDTH  sign-extended imm16 (zero-extended for XORI)
target  out  26  jump target field
regWr, memWr, memToReg, ALUsrc, jump, branch  out  1 each  control
ALUcntrl  out  2  0 add, 1 sub, 2 slt, 3 xor
illegal  out  1  unsupported opcode/funct
stall_cnt, illegal_cnt  out  CNT_WIDTH  saturating counters

Behaviour:
- Decode table (op, funct in hex). Every control not listed is 0.
  - LW 23: regWr, memToReg, ALUsrc, add.
  - SW 2b: memWr, ALUsrc, add.
  - ADDI 08: regWr, ALUsrc, add.
  - XORI 0e: regWr, ALUsrc, xor, zero-extended.
  - BEQ 04 / BNE 05: branch, xor.
  - J 02: jump.
  - JAL 03: jump, regWr, wr_reg=31.
  - op 00: ADD 20 (regWr, regDst, add), SUB 22 (sub), SLT 2a (slt), JR 08 (jump only).
  - Anything else: illegal=1, all write/branch/jump controls 0, ALUcntrl 0.
- Source usage:
  - reads_rs: all except J and JAL.
  - reads_rt: ADD, SUB, SLT, BEQ, BNE, SW.
- Output register load: when in_valid && in_ready. Latency is one cycle from accept to out_valid.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Hazard: out_valid && out memToReg && out wr_reg!=0 && in_valid, and the incoming instruction either reads_rs with rs==out wr_reg or reads_rt with rt==out wr_reg.
  - While hazard holds and out_ready=1, the output register becomes a bubble (out_valid 0 next cycle).
  - The dependent instruction is accepted on the following cycle.
  - stall_cnt increments once per bubble inserted.
- Output hold: out_valid && !out_ready holds all outputs stable, regardless of in_valid.
- Flush: out_valid=0 next cycle; the incoming instruction is dropped (in_ready=0). Flush takes priority over load, hold and hazard. Counters do not change on flush.
- illegal_cnt increments when an illegal instruction is accepted. It does not count on decode-only or on flushed instructions.
- Counters saturate at all-ones; no wrap.
- Reset (async, any time including mid-stall): out_valid=0, all decoded outputs 0, counters 0. in_ready is 1 on the first cycle after deassertion.
- Register 0 destination never triggers a hazard.

Test Plan:
- Reset, then stream ADD 0x012A4020 with out_ready=1 -> out_valid=1 next cycle, rs=9, rt=10, wr_reg=8, regWr=1, ALUcntrl=0, no bubbles over 8 back-to-back instructions.
- LW 0x8C880004 (rt=8) followed by ADD reading $8 -> one bubble cycle (out_valid=0), in_ready=0 for that cycle, stall_cnt=1, ADD emerges on the next cycle. Repeat with LW to $0 -> no bubble.
- Sign/zero extension: ADDI imm 0xFFFC -> imm_ext=0xFFFFFFFC. XORI imm 0xFFFC -> imm_ext=0x0000FFFC. JAL -> wr_reg=31, jump=1, regWr=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs held constant, in_ready=0, no instruction lost or duplicated after release.
- flush asserted during a hazard stall -> out_valid=0 next cycle, incoming dropped, stall_cnt unchanged.
- Illegal op 0x3F accepted twice -> illegal=1, regWr=memWr=0, illegal_cnt=2. Async reset asserted mid-stream -> all outputs and counters 0 immediately.
